// File: rtl/diagv2_test_sequencer.sv
// Regression sequencer: loads, resets, runs and judges NUM_TESTS diagv2 test images back-to-back.
// All outputs registered except core_run, which drops combinationally on ecall so the core freezes that cycle.
module diagv2_test_sequencer #(
  parameter int NUM_TESTS      = 50,
  parameter int DATA_BITS      = 64,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int RESET_CYCLES   = 2,
  parameter int EXIT_SYSCALL   = 93,
  parameter int IDX_BITS       = $clog2(NUM_TESTS),
  parameter int CNT_BITS       = $clog2(NUM_TESTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 load_req,
  output logic [IDX_BITS-1:0]  load_idx,
  input  logic                 load_done,
  output logic                 core_reset,
  output logic                 core_run,
  input  logic                 ecall,
  input  logic [DATA_BITS-1:0] syscall,
  input  logic [DATA_BITS-1:0] arg0,
  output logic                 result_valid,
  output logic [IDX_BITS-1:0]  result_idx,
  output logic                 result_pass,
  output logic                 result_timeout,
  output logic                 result_bad_ecall,
  output logic [7:0]           result_code,
  output logic [CNT_BITS-1:0]  passed_cnt,
  output logic [CNT_BITS-1:0]  failed_cnt,
  output logic                 done
);
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RC_BITS = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RST_HOLD, S_RUN, S_REPORT, S_DONE} state_t;

  state_t              state;
  logic [IDX_BITS-1:0] idx;
  logic [WD_BITS-1:0]  wdog;
  logic [RC_BITS-1:0]  hold_cnt;
  logic                is_exit;
  logic                last_test;
  logic                wdog_last;

  assign load_idx  = idx;
  assign core_run  = (state == S_RUN) & ~ecall;
  assign is_exit   = (syscall == DATA_BITS'(EXIT_SYSCALL));
  assign last_test = (idx == IDX_BITS'(NUM_TESTS - 1));
  assign wdog_last = (wdog == WD_BITS'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      idx              <= '0;
      wdog             <= '0;
      hold_cnt         <= '0;
      load_req         <= 1'b0;
      core_reset       <= 1'b1;
      result_valid     <= 1'b0;
      result_idx       <= '0;
      result_pass      <= 1'b0;
      result_timeout   <= 1'b0;
      result_bad_ecall <= 1'b0;
      result_code      <= 8'd0;
      passed_cnt       <= '0;
      failed_cnt       <= '0;
      done             <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LOAD;
            idx        <= '0;
            passed_cnt <= '0;
            failed_cnt <= '0;
            done       <= 1'b0;
            load_req   <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_done) begin
            load_req <= 1'b0;
            hold_cnt <= '0;
            state    <= S_RST_HOLD;
          end
        end
        S_RST_HOLD: begin
          if (hold_cnt == RC_BITS'(RESET_CYCLES - 1)) begin
            core_reset <= 1'b0;
            wdog       <= '0;
            state      <= S_RUN;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // An ecall on the watchdog's final cycle still counts as an ecall, not a timeout.
          if (ecall || wdog_last) begin
            state            <= S_REPORT;
            core_reset       <= 1'b1;
            result_valid     <= 1'b1;
            result_idx       <= idx;
            result_pass      <= ecall & is_exit & (arg0 == '0);
            result_timeout   <= ~ecall;
            result_bad_ecall <= ecall & ~is_exit;
            result_code      <= (ecall & is_exit) ? arg0[7:0] : 8'd0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_REPORT: begin
          if (result_pass) passed_cnt <= passed_cnt + 1'b1;
          else             failed_cnt <= failed_cnt + 1'b1;
          if (last_test) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx      <= idx + 1'b1;
            load_req <= 1'b1;
            state    <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_diagv2_test_sequencer.sv
// Bench for diagv2_test_sequencer: scripted and random test campaigns driving a mock loader and core.
`timescale 1ns/1ps
module tb_diagv2_test_sequencer;
  localparam int NT = 3;
  localparam int DB = 64;
  localparam int TO = 16;
  localparam int RC = 2;
  localparam int EXITSC = 93;
  localparam int IB = $clog2(NT);
  localparam int CB = $clog2(NT + 1);

  logic          clk = 1'b0;
  logic          reset, start, load_done, ecall;
  logic [DB-1:0] syscall, arg0;
  logic          load_req, core_reset, core_run, result_valid;
  logic [IB-1:0] load_idx, result_idx;
  logic          result_pass, result_timeout, result_bad_ecall, done;
  logic [7:0]    result_code;
  logic [CB-1:0] passed_cnt, failed_cnt;

  always #5 clk = ~clk;

  diagv2_test_sequencer #(
    .NUM_TESTS(NT), .DATA_BITS(DB), .TIMEOUT_CYCLES(TO),
    .RESET_CYCLES(RC), .EXIT_SYSCALL(EXITSC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_req(load_req), .load_idx(load_idx), .load_done(load_done),
    .core_reset(core_reset), .core_run(core_run),
    .ecall(ecall), .syscall(syscall), .arg0(arg0),
    .result_valid(result_valid), .result_idx(result_idx), .result_pass(result_pass),
    .result_timeout(result_timeout), .result_bad_ecall(result_bad_ecall),
    .result_code(result_code), .passed_cnt(passed_cnt), .failed_cnt(failed_cnt),
    .done(done)
  );

  // One test image's scenario: loader delay, RUN cycle of the ecall (-1 = never), and expected verdict.
  typedef struct {
    int          delay;
    int          ecall_at;
    logic [63:0] sc;
    logic [63:0] a0;
    logic        e_pass;
    logic        e_to;
    logic        e_bad;
    logic [7:0]  e_code;
  } vec_t;

  vec_t tbl[9];
  vec_t cur[NT];
  int   vec_cnt = 0;
  int   miss_cnt = 0;
  int   pass_m, fail_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.e_pass = 1'b0; r.e_to = 1'b0; r.e_bad = 1'b0; r.e_code = 8'd0;
    if (v.ecall_at < 0 || v.ecall_at >= TO) r.e_to = 1'b1;
    else if (v.sc == 64'(EXITSC)) begin
      r.e_pass = (v.a0 == 64'd0);
      r.e_code = v.a0[7:0];
    end else r.e_bad = 1'b1;
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int   kind;
    v.delay = $urandom_range(0, 4);
    v.ecall_at = $urandom_range(0, TO - 1);
    v.sc = 64'(EXITSC);
    v.a0 = {$urandom, $urandom};
    kind = $urandom_range(0, 3);
    if (kind == 0) v.ecall_at = -1;
    else if (kind == 1) v.a0 = 64'd0;
    else if (kind == 3) begin
      v.sc = {$urandom, $urandom};
      if (v.sc == 64'(EXITSC)) v.sc = 64'd64;
    end
    return model(v);
  endfunction

  task automatic run_test(input int i, input vec_t v);
    int t, n, c, exp_c;
    t = 0;
    while (!load_req && t < 50) begin @(negedge clk); t++; end
    chk("load_req_up", load_req, 1);
    chk("load_idx", load_idx, i);
    for (int d = 0; d < v.delay; d++) begin
      @(negedge clk);
      chk("load_hold", {load_req, load_idx}, {1'b1, IB'(i)});
    end
    load_done = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    chk("load_req_drop", load_req, 0);
    n = 0;
    while (core_reset && n < 20) begin n++; @(negedge clk); end
    chk("rst_hold_cycles", n, RC);
    c = 0;
    while (!result_valid && c < 40) begin
      if (c == 0) chk("core_run_on", core_run, 1);
      if (c == v.ecall_at) begin
        ecall = 1'b1; syscall = v.sc; arg0 = v.a0;
        #1;
        chk("core_run_ecall", core_run, 0);
      end
      @(negedge clk);
      ecall = 1'b0;
      c++;
    end
    exp_c = (v.ecall_at >= 0 && v.ecall_at < TO) ? v.ecall_at + 1 : TO;
    chk("run_cycles", c, exp_c);
    chk("result_valid", result_valid, 1);
    chk("result_idx", result_idx, i);
    chk("result_flags", {result_pass, result_timeout, result_bad_ecall}, {v.e_pass, v.e_to, v.e_bad});
    chk("result_code", result_code, v.e_code);
    chk("report_core", {core_reset, core_run}, 2'b10);
    chk("cnt_before", {passed_cnt, failed_cnt}, {CB'(pass_m), CB'(fail_m)});
    if (v.e_pass) pass_m++; else fail_m++;
    @(negedge clk);
    chk("result_pulse", result_valid, 0);
    chk("result_hold", {result_pass, result_timeout, result_bad_ecall, result_code},
        {v.e_pass, v.e_to, v.e_bad, v.e_code});
    chk("cnt_after", {passed_cnt, failed_cnt}, {CB'(pass_m), CB'(fail_m)});
  endtask

  task automatic run_campaign();
    pass_m = 0; fail_m = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NT; i++) run_test(i, cur[i]);
    chk("done", done, 1);
    chk("done_core", {core_reset, core_run, load_req}, 3'b100);
    @(negedge clk);
    chk("done_hold", {done, passed_cnt, failed_cnt}, {1'b1, CB'(pass_m), CB'(fail_m)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{1, 10, 64'd93, 64'd0,     1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1, 10, 64'd93, 64'd0,     1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2] = '{1, 10, 64'd93, 64'd0,     1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3] = '{1, 10, 64'd93, 64'd0,     1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4] = '{1, 10, 64'd93, 64'd3,     1'b0, 1'b0, 1'b0, 8'd3};
    tbl[5] = '{5, -1, 64'd0,  64'd0,     1'b0, 1'b1, 1'b0, 8'd0};
    tbl[6] = '{0, 4,  64'd64, 64'd7,     1'b0, 1'b0, 1'b1, 8'd0};
    tbl[7] = '{2, 15, 64'd93, 64'd0,     1'b1, 1'b0, 1'b0, 8'd0};
    tbl[8] = '{3, 0,  64'd93, 64'h1FF,   1'b0, 1'b0, 1'b0, 8'hFF};

    reset = 1'b0; start = 1'b0; load_done = 1'b0; ecall = 1'b0;
    syscall = '0; arg0 = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {core_reset, load_req, core_run, result_valid, done}, 5'b10000);
    chk("rst_counts", {passed_cnt, failed_cnt, load_idx}, '0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_quiet", {load_req, core_reset}, 2'b01);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NT; i++) cur[i] = tbl[k * NT + i];
      run_campaign();
    end
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NT; i++) cur[i] = rand_vec();
      run_campaign();
    end

    // Reset dropped mid-RUN after one passing test, with a stray start that must be ignored.
    pass_m = 0; fail_m = 0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    run_test(0, tbl[0]);
    n = 0;
    while (!load_req && n < 50) begin @(negedge clk); n++; end
    load_done = 1'b1; @(negedge clk); load_done = 1'b0;
    n = 0;
    while (core_reset && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("start_ignored_run", {core_run, core_reset, load_req}, 3'b100);
    chk("pre_reset_cnt", passed_cnt, 1);
    reset = 1'b0;
    #1;
    chk("midrun_reset", {core_reset, core_run, load_req, done, result_pass}, 5'b10000);
    chk("midrun_reset_cnt", {passed_cnt, failed_cnt, load_idx}, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("after_reset_idle", load_req, 0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("restart_idx", {load_req, load_idx}, {1'b1, IB'(0)});
    reset = 1'b0;
    #1;
    chk("reset_drops_load_req", {load_req, core_reset}, 2'b01);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule

// File: doc/diagv2_test_sequencer.md
Name: diagv2_test_sequencer

Overview:
- Synthesizable regression sequencer for the diagv2 core; runs NUM_TESTS ISA test images back-to-back without bench intervention.
- Per test: requests an image load from an external loader, holds the core in reset, runs it, and stops it on ecall or watchdog timeout.
- Decodes the EXIT ecall, reports a per-test verdict, and accumulates pass/fail counts.
- Sits between the loader/bench and diagv2_top; drives core reset and a core clock-enable.

Parameters:
NUM_TESTS, 50, number of test images, indexed 0..NUM_TESTS-1
DATA_BITS, 64, width of the syscall/arg0 register taps
TIMEOUT_CYCLES, 100000, RUN cycles allowed per test before forced fail
RESET_CYCLES, 2, cycles core_reset is held after each load (>=1)
EXIT_SYSCALL, 93, a7 value meaning EXIT
IDX_BITS, $clog2(NUM_TESTS), width of test index
CNT_BITS, $clog2(NUM_TESTS+1), width of pass/fail counters

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; starts a run from IDLE or DONE
load_req  out  1  request image load for load_idx
load_idx  out  IDX_BITS  test index to load; stable while load_req=1
load_done  in  1  loader acknowledge; imem/dmem written
core_reset  out  1  active-high reset to core
core_run  out  1  core clock enable
ecall  in  1  core ecall indication
syscall  in  DATA_BITS  x17/a7 value
arg0  in  DATA_BITS  x10/a0 value
result_valid  out  1  one-cycle verdict pulse
result_idx  out  IDX_BITS  index of the reported test
result_pass  out  1  1 = EXIT with arg0==0
result_timeout  out  1  watchdog expired
result_bad_ecall  out  1  ecall with syscall!=EXIT_SYSCALL
result_code  out  8  arg0[7:0] on EXIT, else 0
passed_cnt  out  CNT_BITS  tests passed
failed_cnt  out  CNT_BITS  tests failed
done  out  1  all tests reported

Behaviour:
- Reset state: IDLE. core_reset=1; load_req, core_run, result_*, done = 0; counters = 0; load_idx = 0.
- States: IDLE, LOAD, RST_HOLD, RUN, REPORT, DONE.
- IDLE: on start, clear counters, idx=0, go to LOAD.
- LOAD:
  - load_req=1 from the first LOAD cycle; stays asserted until load_done is sampled high.
  - load_done sampled -> load_req=0 next cycle; go to RST_HOLD.
  - load_done outside LOAD is ignored.
- RST_HOLD: core_reset=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN:
  - core_reset=0; watchdog counts from 0.
  - core_run = (state==RUN) & ~ecall, combinational, so the core freezes in the same cycle ecall is seen.
  - ecall & syscall==EXIT_SYSCALL: pass = (arg0==0), code = arg0[7:0]; go to REPORT.
  - ecall & other syscall: bad_ecall=1, pass=0, code=0; go to REPORT.
  - No ecall and watchdog == TIMEOUT_CYCLES-1: timeout=1, pass=0, code=0; go to REPORT.
  - ecall and timeout in the same cycle: ecall wins; timeout=0.
- REPORT:
  - Exactly one cycle with result_valid=1; result_idx = current idx.
  - core_run=0; core_reset=1.
  - passed_cnt or failed_cnt increments by 1; counter updates are visible the cycle after result_valid.
  - If idx==NUM_TESTS-1 go to DONE; else idx+1 and go to LOAD.
- DONE: done=1, core_reset=1, core_run=0. start restarts from index 0 and clears counters and done.
- start is ignored in LOAD, RST_HOLD, RUN and REPORT.
- result_* fields hold their value after the pulse until the next REPORT; only result_valid is a pulse.
- reset asserted mid-operation: immediate return to the reset state, including with load_req pending; the loader must tolerate a dropped request.
- Counters cannot overflow, since CNT_BITS covers NUM_TESTS.

Test Plan:
- NUM_TESTS=3, loader acks after 1 cycle, each test ecall syscall=93 arg0=0 after 10 RUN cycles -> three result_valid pulses, idx 0,1,2, passed_cnt=3, failed_cnt=0, done=1.
- Test 1 exits with arg0=3 -> result_pass=0, result_code=3, failed_cnt=1; test 2 still loads with load_idx=2.
- TIMEOUT_CYCLES=16, no ecall -> result_timeout=1 exactly 16 RUN cycles after entry; core_run=0 in REPORT; next test proceeds.
- ecall syscall=64 -> result_bad_ecall=1, result_code=0, failed_cnt+1; core_run low in the ecall cycle.
- ecall syscall=93 arg0=0 on the watchdog's last cycle -> pass=1, timeout=0.
- load_done delayed 5 cycles with load_idx stable; reset pulled low during RUN -> core_reset=1, counters 0, state IDLE; start afterwards begins at idx 0.
